// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam logic [31:0] HALT_TARGET = 32'hFFFF_FFFF;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
    } ifid_t;

    // A bubble keeps the previous PC tag; only valid/instr carry meaning.
    function automatic ifid_t ifid_bubble(input logic [31:0] pc);
        ifid_bubble = '{pc: pc, instr: NOP_INSTR, valid: 1'b0};
    endfunction

endpackage

// File: rtl/fetch_perf_counters.sv
// Saturating fetch/flush event counters; present only when FETCH_PERF_CNT_EN is defined.
module fetch_perf_counters
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_inc,
    input  logic        flush_inc,
    output logic [31:0] fetch_count,
    output logic [31:0] flush_count
);

    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (fetch_inc && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (flush_inc && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fetch_count = fetch_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID register, redirect/flush and halt FSM.
// Define FETCH_PERF_CNT_EN to add the fetch_count / flush_count performance outputs.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = 9,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             pc_sel,
    input  logic [31:0]      branch_pc,
    output logic [WIDTH-1:0] instr_addr,
    input  logic [31:0]      instr_rdata,
    output logic [WIDTH-1:0] ifid_pc,
    output logic [31:0]      ifid_instr,
    output logic             ifid_valid,
    output logic             flush,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]      fetch_count,
    output logic [31:0]      flush_count,
`endif
    output logic             halted
);

    fetch_state_t     state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    ifid_t            ifid_q, ifid_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ifid_d  = ifid_q;
        flush   = 1'b0;
        if (state_q == RUN) begin
            if (pc_sel && (branch_pc == HALT_TARGET)) begin
                state_d = HALTED;
                ifid_d  = ifid_bubble(ifid_q.pc);
                flush   = 1'b1;
            end else if (pc_sel) begin
                pc_d   = {branch_pc[WIDTH-1:2], 2'b00};
                ifid_d = ifid_bubble(ifid_q.pc);
                flush  = 1'b1;
            end else if (!stall) begin
                pc_d   = pc_q + WIDTH'(4);
                ifid_d = '{pc: 32'(pc_q), instr: instr_rdata, valid: 1'b1};
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            ifid_q  <= '{pc: 32'd0, instr: NOP_INSTR, valid: 1'b0};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ifid_q  <= ifid_d;
        end
    end

    assign instr_addr = pc_q;
    assign ifid_pc    = ifid_q.pc[WIDTH-1:0];
    assign ifid_instr = ifid_q.instr;
    assign ifid_valid = ifid_q.valid;
    assign halted     = (state_q == HALTED);

    // The IF/ID PC tag is 32 bits wide; bits above WIDTH are always zero.
    generate
        if (WIDTH < 32) begin : g_pc_hi
            logic unused_pc_hi;
            assign unused_pc_hi = |ifid_q.pc[31:WIDTH];
        end
    endgenerate

`ifdef FETCH_PERF_CNT_EN
    logic fetch_inc;

    // In RUN with no redirect and no stall, this edge loads a real instruction.
    assign fetch_inc = (state_q == RUN) && !pc_sel && !stall;

    fetch_perf_counters u_perf (
        .clk        (clk),
        .rst_n      (reset),
        .fetch_inc  (fetch_inc),
        .flush_inc  (flush),
        .fetch_count(fetch_count),
        .flush_count(flush_count)
    );
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage RISC-V pipeline. It owns the program counter, drives the instruction-memory address and loads the IF/ID pipeline register. It sits directly downstream of the branch-resolution logic and consumes its `pc_sel`/`branch_pc` pair to redirect fetch, flush the wrong-path instruction and detect halt.

## Interface
- `WIDTH`, 9: PC / instruction-memory byte-address width in bits.
- `RESET_PC`, 0: PC value loaded on reset; `WIDTH` bits, word-aligned.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `stall`  in  1  from the hazard unit; holds PC and IF/ID.
- `pc_sel`  in  1  redirect request from branch resolution; 1 = take `branch_pc`.
- `branch_pc`  in  32  redirect target; `32'hFFFFFFFF` with `pc_sel`=1 means halt.
- `instr_addr`  out  WIDTH  instruction-memory address (the PC register).
- `instr_rdata`  in  32  instruction word; combinational read of `instr_addr`.
- `ifid_pc`  out  WIDTH  PC of the instruction held in IF/ID.
- `ifid_instr`  out  32  instruction held in IF/ID.
- `ifid_valid`  out  1  IF/ID holds a real instruction; 0 = bubble.
- `flush`  out  1  combinational; 1 while a redirect is accepted, so downstream clears ID/EX.
- `halted`  out  1  fetch has stopped permanently.

## Operation
- FSM states are RUN and HALTED; reset enters RUN.
- Per-edge priority in RUN: halt > redirect > stall > sequential.
- **Halt** (`pc_sel`=1 and `branch_pc`=`32'hFFFFFFFF`):
  - go to HALTED; PC frozen.
  - IF/ID loaded with a bubble (`ifid_valid`=0, `ifid_instr`=NOP `32'h00000013`).
  - `flush`=1 in that cycle.
- **Redirect** (`pc_sel`=1, not halt):
  - PC <= `branch_pc[WIDTH-1:0]` with bits [1:0] forced to 0.
  - IF/ID loaded with a bubble; `flush`=1.
  - Overrides `stall`.
- **Stall** (`stall`=1, `pc_sel`=0): PC and IF/ID hold their values.
- **Sequential**: PC <= PC+4, truncated to `WIDTH`; wraps modulo 2^WIDTH (max word address to 0).
  - IF/ID <= {PC, `instr_rdata`, valid=1}.
- **HALTED**:
  - PC and IF/ID hold; `ifid_valid`=0, `halted`=1, `flush`=0.
  - `stall` and `pc_sel` are ignored.
  - Exit only via reset.
- `branch_pc[31:WIDTH]` is ignored except for halt detection.

## Timing
- Reset values (asynchronous, immediate):
  - PC=`RESET_PC`; `ifid_pc`=0; `ifid_instr`=`32'h00000013`; `ifid_valid`=0; `halted`=0.
  - `flush`=0 while `pc_sel` is low.
- First valid IF/ID entry appears one edge after reset deasserts, with `ifid_pc`=`RESET_PC`.
- Redirect accepted in cycle N:
  - after edge N+1: PC=target, IF/ID=bubble.
  - after edge N+2: IF/ID holds the instruction at target.
  - Branch penalty is one bubble from this stage.
- Halt accepted in cycle N: `halted`=1 after edge N+1.
- Reset asserted mid-operation, including in HALTED: all state returns to reset values on assertion, independent of `clk`.

## Configuration
- `FETCH_PERF_CNT_EN` defined: adds outputs `fetch_count` (32) and `flush_count` (32), both reset to 0.
  - `fetch_count` increments on each edge that loads a valid instruction into IF/ID.
  - `flush_count` increments on each accepted redirect or halt.
  - Both saturate at `32'hFFFFFFFF`.
- Undefined: ports and counters absent; all other behaviour identical.

## Structure
- Package `fetch_pkg` holds:
  - `NOP_INSTR` = `32'h00000013`.
  - `HALT_TARGET` = `32'hFFFFFFFF`.
  - `fetch_state_t` enum {RUN, HALTED}.
  - `ifid_t` struct {pc, instr, valid}.
- Sub-module `fetch_perf_counters` holds both saturating counters; instantiated only under `FETCH_PERF_CNT_EN`.

## Test plan
- Reset release, no stall: `instr_addr` runs 0, 4, 8, …; `ifid_pc` lags by one cycle; `ifid_valid`=1 from the first edge.
- `stall`=1 for 3 cycles at PC=0x10: `instr_addr` stays 0x10 and IF/ID holds; resumes at 0x14 after `stall` drops.
- `pc_sel`=1, `branch_pc`=0x40, with `stall`=1 in the same cycle:
  - `flush`=1; next cycle PC=0x40 and `ifid_valid`=0.
  - following cycle `ifid_pc`=0x40.
- PC=0x1FC (`WIDTH`=9), sequential: PC wraps to 0x000. `branch_pc`=0x23 redirects to 0x20.
- `pc_sel`=1, `branch_pc`=`32'hFFFFFFFF`: `halted`=1 next cycle; PC frozen; later `pc_sel` pulses are ignored; asserting `reset` clears `halted`.
- With `FETCH_PERF_CNT_EN`: 10 sequential fetches, then 2 redirects → `fetch_count`=10, `flush_count`=2.
